countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Four-digit BCD countdown timer (SS.hh, 00.00-99.99 s): the count-down counterpart of the stopwatch.
//  Loads a BCD preset, decrements once per hundredth-second tick while running, pauses/resumes on a
//  start/stop pulse, stops at 00.00 and flags completion. Drives the same four 7-segment digits.
// PARAMETERS
//  TICK_DIV  10  clock cycles per hundredth-second tick (>=2; 1_000_000 for real 100 MHz hardware)
// PORTS
//  clk100_i      in   1   system clock; single clock domain
//  rst_i         in   1   asynchronous, active-high reset
//  start_stop_i  in   1   synchronous single-cycle pulse: start / pause / resume
//  load_i        in   1   synchronous single-cycle pulse: load preset_i into the count
//  preset_i      in   16  BCD preset {tens_s, secs, tenths, hundredths}, [15:12] most significant
//  running_o     out  1   1 while state==RUN
//  done_o        out  1   one-cycle pulse when the count reaches 00.00 from a decrement
//  hex0_o        out  7   hundredths digit, active-low segments, bit0=a .. bit6=g
//  hex1_o        out  7   tenths digit
//  hex2_o        out  7   seconds digit
//  hex3_o        out  7   tens-of-seconds digit
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, count=0000, prescaler=0, running_o=0, done_o=0,
//   all hex_o=7'b1000000 ("0"). Reset mid-RUN aborts immediately; no done_o.
//  States: IDLE, RUN, PAUSE, DONE (registered FSM).
//   IDLE : load_i -> count<=preset; start_stop_i and count!=0 -> RUN, prescaler<=0; count==0 -> stay.
//   RUN  : start_stop_i -> PAUSE (count and prescaler hold); load_i ignored.
//   PAUSE: start_stop_i -> RUN (prescaler resumes from held value); load_i -> count<=preset, IDLE.
//   DONE : start_stop_i ignored; load_i -> count<=preset, IDLE.
//  Same-cycle load_i and start_stop_i: load_i wins, start_stop_i dropped (all states except RUN,
//   where load_i is ignored and start_stop_i acts).
//  Prescaler (RUN only): counts 0..TICK_DIV-1; at TICK_DIV-1 wraps to 0 and issues a tick.
//   First decrement occurs TICK_DIV cycles after the edge that entered RUN.
//  Tick: count decremented as 4-digit BCD with borrow (each digit 0 -> 9, borrow to next);
//   e.g. 1000 -> 0999, 0100 -> 0099. Never decrements below 0000.
//  Tick that yields count==0000: same edge sets state=DONE, running_o=0, done_o=1 for exactly one cycle.
//  Preset sanitising: any preset digit > 9 is loaded as 9 (per digit).
//  running_o, done_o registered. hex*_o combinational decode of the registered count digits
//   (visible the same cycle the count register updates). Digit map 0..9 standard 7-seg, active-low.
// TESTING (TICK_DIV=10)
//  Assert rst_i -> hex0..3=7'b1000000, running_o=0, done_o=0 without waiting for a clock edge.
//  Load 0x0012, start -> count 0011 at cycle 10, 0000 at cycle 120; done_o high one cycle there; running_o=0.
//  Load 0x1000, start -> after 10 cycles hex3="0"(7'b1000000), hex2/hex1/hex0="9"(7'b0010000).
//  Load 0x0050, start, pause at cycle 25, hold 100 cycles, resume -> count 0048 frozen during pause;
//   0047 exactly 5 cycles after resume.
//  Load 0x0000, start -> stays IDLE, running_o=0, no done_o; load 0x00A5 -> count 0095.
//  RUN at 0030, assert rst_i -> count 0000, IDLE, done_o never pulses; load+start same cycle in IDLE -> loads, stays IDLE.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control and display bundle for the four-digit BCD countdown timer.
interface countdown_timer_if;
    logic        start_stop_i;
    logic        load_i;
    logic [15:0] preset_i;
    logic        running_o;
    logic        done_o;
    logic [6:0]  hex0_o;
    logic [6:0]  hex1_o;
    logic [6:0]  hex2_o;
    logic [6:0]  hex3_o;

    modport master (
        output start_stop_i, load_i, preset_i,
        input  running_o, done_o, hex0_o, hex1_o, hex2_o, hex3_o
    );

    modport slave (
        input  start_stop_i, load_i, preset_i,
        output running_o, done_o, hex0_o, hex1_o, hex2_o, hex3_o
    );
endinterface

// File: rtl/countdown_timer.sv
// Four-digit BCD countdown timer (SS.hh): loads a preset, counts down once per prescaler tick,
// pauses/resumes on start_stop, stops at 00.00 with a one-cycle done pulse.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 10
) (
    input logic              clk100_i,
    input logic              rst_i,
    countdown_timer_if.slave bus
);
    localparam int unsigned   PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic [15:0]   preset_clean;
    logic [15:0]   count_dec;
    logic          tick;
    logic          last_tick;

    function automatic logic [15:0] sanitise(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    // Ripple-borrow BCD decrement; a zero digit wraps to 9 and passes the borrow upward.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign preset_clean = sanitise(bus.preset_i);
    assign count_dec    = bcd_dec(count_q);
    assign tick         = (state_q == StRun) && !bus.start_stop_i && (presc_q == PrescLast);
    assign last_tick    = tick && (count_q == 16'h0001);

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.load_i && bus.start_stop_i && (count_q != 16'h0000)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.start_stop_i) begin
                    state_d = StPause;
                end else if (last_tick) begin
                    state_d = StDone;
                end
            end
            StPause: begin
                if (bus.load_i) begin
                    state_d = StIdle;
                end else if (bus.start_stop_i) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                if (bus.load_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        presc_d   = presc_q;
        running_d = (state_d == StRun);
        done_d    = last_tick;
        unique case (state_q)
            StIdle: begin
                if (bus.load_i) begin
                    count_d = preset_clean;
                end else if (state_d == StRun) begin
                    presc_d = '0;
                end
            end
            StRun: begin
                if (tick) begin
                    presc_d = '0;
                    if (count_q != 16'h0000) begin
                        count_d = count_dec;
                    end
                end else if (!bus.start_stop_i) begin
                    presc_d = presc_q + 1'b1;
                end
            end
            StPause, StDone: begin
                if (bus.load_i) begin
                    count_d = preset_clean;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= 16'h0000;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.running_o = running_q;
    assign bus.done_o    = done_q;
    assign bus.hex0_o    = seg7(count_q[3:0]);
    assign bus.hex1_o    = seg7(count_q[7:4]);
    assign bus.hex2_o    = seg7(count_q[11:8]);
    assign bus.hex3_o    = seg7(count_q[15:12]);
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: integer-hundredths reference model checked every cycle,
// plus literal display/flag expectations at the key points of each scenario.
module tb_countdown_timer;
    localparam int unsigned TickDiv = 10;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H4 = 7'b0011001;
    localparam logic [6:0] H5 = 7'b0010010;
    localparam logic [6:0] H7 = 7'b1111000;
    localparam logic [6:0] H8 = 7'b0000000;
    localparam logic [6:0] H9 = 7'b0010000;
    localparam logic [6:0] SegTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0010000};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 1'b0;

    countdown_timer_if bus_if ();

    countdown_timer #(.TICK_DIV(TickDiv)) dut (
        .clk100_i (clk),
        .rst_i    (rst),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: count kept as plain integer hundredths, mode 0 idle/1 run/2 pause/3 done.
    int m_cnt   = 0;
    int m_phase = 0;
    int m_mode  = 0;
    bit m_done  = 1'b0;

    function automatic int clean_preset(input logic [15:0] p);
        int v = 0;
        for (int i = 3; i >= 0; i--) begin
            int d = (int'(p) >> (4 * i)) & 15;
            v = v * 10 + ((d > 9) ? 9 : d);
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= 0;
            m_phase <= 0;
            m_mode  <= 0;
            m_done  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            case (m_mode)
                0: begin
                    if (bus_if.load_i) m_cnt <= clean_preset(bus_if.preset_i);
                    else if (bus_if.start_stop_i && m_cnt != 0) begin
                        m_mode  <= 1;
                        m_phase <= 0;
                    end
                end
                1: begin
                    if (bus_if.start_stop_i) m_mode <= 2;
                    else if (m_phase == TickDiv - 1) begin
                        m_phase <= 0;
                        if (m_cnt > 0) m_cnt <= m_cnt - 1;
                        if (m_cnt == 1) begin
                            m_mode <= 3;
                            m_done <= 1'b1;
                        end
                    end else m_phase <= m_phase + 1;
                end
                default: begin
                    if (bus_if.load_i) begin
                        m_cnt  <= clean_preset(bus_if.preset_i);
                        m_mode <= 0;
                    end else if (m_mode == 2 && bus_if.start_stop_i) m_mode <= 1;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] dut_hex();
        return {bus_if.hex3_o, bus_if.hex2_o, bus_if.hex1_o, bus_if.hex0_o};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model", {2'b00, bus_if.running_o, bus_if.done_o, dut_hex()},
                  {2'b00, (m_mode == 1), m_done, SegTab[(m_cnt / 1000) % 10],
                   SegTab[(m_cnt / 100) % 10], SegTab[(m_cnt / 10) % 10], SegTab[m_cnt % 10]});
        end
    end

    task automatic drive(input logic ld, input logic ss, input logic [15:0] pre);
        bus_if.load_i       = ld;
        bus_if.start_stop_i = ss;
        bus_if.preset_i     = pre;
        @(negedge clk);
        bus_if.load_i       = 1'b0;
        bus_if.start_stop_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus_if.load_i       = 1'b0;
        bus_if.start_stop_i = 1'b0;
        bus_if.preset_i     = 16'h0000;
        #2 rst = 1'b1;
        #1;
        check("reset_hex", dut_hex(), {H0, H0, H0, H0});
        check("reset_flags", {bus_if.running_o, bus_if.done_o}, 2'b00);
        cmp_en = 1'b1;
        wait_cycles(2);
        rst = 1'b0;

        // 00.12 counts to zero in 120 cycles
        drive(1'b1, 1'b0, 16'h0012);
        drive(1'b0, 1'b1, 16'h0000);
        wait_cycles(10);
        check("first_tick_hex", dut_hex(), {H0, H0, H1, H1});
        check("first_tick_run", bus_if.running_o, 1'b1);
        wait_cycles(109);
        check("pre_done", {bus_if.done_o, dut_hex()}, {1'b0, H0, H0, H0, H1});
        wait_cycles(1);
        check("done_edge", {bus_if.running_o, bus_if.done_o, dut_hex()},
              {2'b01, H0, H0, H0, H0});
        wait_cycles(1);
        check("done_one_cycle", bus_if.done_o, 1'b0);
        drive(1'b0, 1'b1, 16'h0000);
        check("done_ignores_start", bus_if.running_o, 1'b0);

        // 10.00 borrows through every digit; load ignored in RUN; load+start in RUN pauses
        drive(1'b1, 1'b0, 16'h1000);
        drive(1'b0, 1'b1, 16'h0000);
        wait_cycles(10);
        check("borrow_hex", dut_hex(), {H0, H9, H9, H9});
        drive(1'b1, 1'b0, 16'h0555);
        check("run_ignores_load", dut_hex(), {H0, H9, H9, H9});
        drive(1'b1, 1'b1, 16'h0222);
        check("run_both_pauses", {bus_if.running_o, dut_hex()}, {1'b0, H0, H9, H9, H9});

        // Pause mid-tick, resume keeps the prescaler phase
        drive(1'b1, 1'b0, 16'h0050);
        drive(1'b0, 1'b1, 16'h0000);
        wait_cycles(25);
        drive(1'b0, 1'b1, 16'h0000);
        check("paused", {bus_if.running_o, dut_hex()}, {1'b0, H0, H0, H4, H8});
        wait_cycles(100);
        check("pause_frozen", dut_hex(), {H0, H0, H4, H8});
        drive(1'b0, 1'b1, 16'h0000);
        wait_cycles(4);
        check("resume_hold", {bus_if.running_o, dut_hex()}, {1'b1, H0, H0, H4, H8});
        wait_cycles(1);
        check("resume_tick", dut_hex(), {H0, H0, H4, H7});

        // Zero preset cannot start; digit sanitising
        drive(1'b0, 1'b1, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000);
        wait_cycles(20);
        check("zero_no_start", {bus_if.running_o, bus_if.done_o, dut_hex()},
              {2'b00, H0, H0, H0, H0});
        drive(1'b1, 1'b0, 16'h00A5);
        check("sanitise_a5", dut_hex(), {H0, H0, H9, H5});

        // Async reset mid-run, then load+start together in IDLE
        drive(1'b1, 1'b0, 16'h0030);
        drive(1'b0, 1'b1, 16'h0000);
        wait_cycles(5);
        #3 rst = 1'b1;
        #1;
        check("midrun_reset", {bus_if.running_o, bus_if.done_o, dut_hex()},
              {2'b00, H0, H0, H0, H0});
        wait_cycles(3);
        rst = 1'b0;
        drive(1'b1, 1'b1, 16'h0042);
        check("idle_load_wins", {bus_if.running_o, dut_hex()}, {1'b0, H0, H0, H4, H2});
        wait_cycles(15);
        check("idle_stays", {bus_if.running_o, dut_hex()}, {1'b0, H0, H0, H4, H2});

        // Every digit clamped, then one tick from 99.99
        drive(1'b1, 1'b0, 16'hFA9C);
        check("sanitise_all", dut_hex(), {H9, H9, H9, H9});
        drive(1'b0, 1'b1, 16'h0000);
        wait_cycles(10);
        check("tick_9999", dut_hex(), {H9, H9, H9, H8});

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
